// File: rtl/sprite_blitter.sv
// Sprite blitter: copies a w x h sprite from on-chip memory into the SRAM frame buffer.
// Processes one pixel every 3 cycles (FETCH, DATA, WRITE). Off-screen and transparent pixels are skipped.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; inputs latched when start is accepted
// S_FETCH | src_addr presents the current pixel address to on_chip_mem
// S_DATA  | palette colour valid; clip/transparency decision registered
// S_WRITE | SRAM write strobe (if enabled); advance col/row
// S_DONE  | one-cycle done pulse
module sprite_blitter #(
    parameter int          SrcAddrWidth = 22,
    parameter int          FB_W         = 640,
    parameter int          FB_H         = 480,
    parameter logic [15:0] TRANSPARENT  = 16'h0000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [SrcAddrWidth-1:0] sprite_base,
    input  logic [7:0]              sprite_w,
    input  logic [7:0]              sprite_h,
    input  logic [9:0]              dst_x,
    input  logic [9:0]              dst_y,
    output logic                    busy,
    output logic                    done,
    output logic [SrcAddrWidth-1:0] src_addr,
    input  logic [15:0]             src_data,
    output logic [19:0]             sram_addr,
    output logic [15:0]             sram_wdata,
    output logic                    sram_dq_oe,
    output logic                    sram_we_n,
    output logic                    sram_ce_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [10:0] FbW11  = 11'(FB_W);
    localparam logic [10:0] FbH11  = 11'(FB_H);
    localparam logic [19:0] FbWRow = 20'(FB_W);

    state_t                  state_q, state_d;
    logic [SrcAddrWidth-1:0] src_ptr_q, src_ptr_d;
    logic [7:0]              w_q, w_d, h_q, h_d;
    logic [9:0]              dx_q, dx_d, dy_q, dy_d;
    logic [7:0]              col_q, col_d, row_q, row_d;
    logic [19:0]             row_base_q, row_base_d;
    logic [19:0]             sram_addr_q, sram_addr_d;
    logic [15:0]             sram_wdata_q, sram_wdata_d;
    logic                    we_n_q, we_n_d;
    logic                    dq_oe_q, dq_oe_d;
    logic                    ce_n_q, ce_n_d;

    logic [10:0] sx, sy;
    logic        wr_en;
    logic        last_col, last_row;
    logic [19:0] row_base_init;

    assign sx            = {1'b0, dx_q} + {3'b0, col_q};
    assign sy            = {1'b0, dy_q} + {3'b0, row_q};
    assign wr_en         = (sx < FbW11) && (sy < FbH11) && (src_data != TRANSPARENT);
    assign last_col      = (col_q == (w_q - 8'd1));
    assign last_row      = (row_q == (h_q - 8'd1));
    // Only the starting row needs a (constant) multiply; later rows add FB_W.
    assign row_base_init = 20'(dst_y) * FbWRow;

    always_comb begin
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        w_d          = w_q;
        h_d          = h_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        col_d        = col_q;
        row_d        = row_q;
        row_base_d   = row_base_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        we_n_d       = 1'b1;
        dq_oe_d      = 1'b0;
        ce_n_d       = ce_n_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_d        = sprite_w;
                    h_d        = sprite_h;
                    dx_d       = dst_x;
                    dy_d       = dst_y;
                    src_ptr_d  = sprite_base;
                    col_d      = 8'd0;
                    row_d      = 8'd0;
                    row_base_d = row_base_init;
                    if ((sprite_w == 8'd0) || (sprite_h == 8'd0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        ce_n_d  = 1'b0;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                sram_wdata_d = src_data;
                sram_addr_d  = row_base_q + {9'b0, sx};
                we_n_d       = ~wr_en;
                dq_oe_d      = wr_en;
                state_d      = S_WRITE;
            end
            S_WRITE: begin
                // Pointer advances for clipped pixels too, keeping source alignment.
                src_ptr_d = src_ptr_q + SrcAddrWidth'(1);
                if (last_col) begin
                    col_d      = 8'd0;
                    row_d      = row_q + 8'd1;
                    row_base_d = row_base_q + FbWRow;
                end else begin
                    col_d = col_q + 8'd1;
                end
                if (last_col && last_row) begin
                    state_d = S_DONE;
                    ce_n_d  = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                ce_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            src_ptr_q    <= '0;
            w_q          <= '0;
            h_q          <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            row_base_q   <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            we_n_q       <= 1'b1;
            dq_oe_q      <= 1'b0;
            ce_n_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            w_q          <= w_d;
            h_q          <= h_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            col_q        <= col_d;
            row_q        <= row_d;
            row_base_q   <= row_base_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            we_n_q       <= we_n_d;
            dq_oe_q      <= dq_oe_d;
            ce_n_q       <= ce_n_d;
        end
    end

    assign busy       = (state_q == S_FETCH) || (state_q == S_DATA) || (state_q == S_WRITE);
    assign done       = (state_q == S_DONE);
    assign src_addr   = src_ptr_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_we_n  = we_n_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Copies one rectangular sprite from on-chip sprite memory into the SRAM frame buffer.
- Generates the read address for on_chip_mem, which has 1-cycle registered read latency.
- Receives the colour produced by zombie_palette, which is combinational from the memory's data output.
- Writes each non-transparent pixel into the 16-bit SRAM frame buffer at its clipped screen position.

Parameters:
- SrcAddrWidth, 22: width of the sprite-memory read address.
- FB_W, 640: frame-buffer width in pixels, which is also the row stride in SRAM words.
- FB_H, 480: frame-buffer height in pixels.
- TRANSPARENT, 16'h0000: palette colour that is never written.

Ports:
- clk  in  1: system clock.
- reset_n  in  1: asynchronous, active-low reset.
- start  in  1: one-cycle request pulse; sampled only in IDLE.
- sprite_base  in  SrcAddrWidth: sprite-memory address of pixel (0,0).
- sprite_w  in  8: sprite width in pixels.
- sprite_h  in  8: sprite height in pixels.
- dst_x  in  10: screen x of sprite pixel (0,0).
- dst_y  in  10: screen y of sprite pixel (0,0).
- busy  out  1: high from the accepted start until DONE.
- done  out  1: one-cycle pulse when the blit completes.
- src_addr  out  SrcAddrWidth: read address to on_chip_mem.
- src_data  in  16: palette colour for the address issued on the previous cycle.
- sram_addr  out  20: frame-buffer word address.
- sram_wdata  out  16: write data.
- sram_dq_oe  out  1: top level drives SRAM_DQ with sram_wdata when high.
- sram_we_n  out  1: SRAM write enable, active low.
- sram_ce_n  out  1: SRAM chip enable, active low.

Behaviour:
- Reset values (asynchronous): state IDLE, busy=0, done=0, src_addr=0, sram_addr=0, sram_wdata=0, sram_dq_oe=0, sram_we_n=1, sram_ce_n=1.
- Latching: start in IDLE captures all inputs into internal registers. Input changes afterwards have no effect.
- Zero-size request: if latched sprite_w or sprite_h is 0, go directly to DONE with no SRAM writes.
- States: IDLE -> FETCH -> DATA -> WRITE -> FETCH … -> DONE -> IDLE.
- FETCH:
  - src_addr = src_ptr, where src_ptr starts at sprite_base and increments by 1 per pixel, row-major, without per-row reset.
  - src_ptr truncates to SrcAddrWidth.
- DATA:
  - src_data is valid in this cycle; register it into sram_wdata.
  - Compute sx = dst_x + col and sy = dst_y + row as 11-bit unsigned values, with no wrap.
  - Write is enabled iff sx < FB_W, sy < FB_H and src_data != TRANSPARENT.
- WRITE:
  - If enabled: sram_addr = row_base + sx, where row_base = sy*FB_W and is maintained incrementally by adding FB_W per row, not by a multiplier. Also drive sram_ce_n=0, sram_dq_oe=1 and sram_we_n=0 for exactly this cycle.
  - If disabled: sram_we_n stays 1 and sram_dq_oe stays 0. The cycle is still consumed, giving a fixed 3 cycles per pixel.
- Advance (at the end of WRITE):
  - col++. When col == sprite_w-1, set col=0 and row++.
  - After the last pixel (row == sprite_h-1, col == sprite_w-1), go to DONE; otherwise go to FETCH.
- DONE: done=1 and busy=0 for one cycle, then IDLE. Total blit latency = 3*w*h + 1 cycles from the cycle after start to the done pulse.
- sram_ce_n is low throughout busy.
- SRAM bus: SRAM_OE is held high by the top level while busy. sram_addr and sram_wdata are stable for the whole WRITE cycle because they are registered on entry.
- start while busy: ignored, with no queuing.
- Reset mid-blit: immediate return to IDLE. sram_we_n deasserts asynchronously. Partial pixels already written remain in SRAM and are not rolled back.
- Clipping: left/top clipping is not needed because dst is unsigned. Right/bottom clipping skips pixels but still fetches them, so src_ptr stays aligned.

Test Plan:
- 2x2 blit, base=0x100, dst=(0,0), all colours 16'h1234 -> src_addr 0x100..0x103 in order; writes at 0, 1, 640, 641; done after 13 cycles.
- 3x1 blit with the middle pixel TRANSPARENT -> writes only at dst and dst+2; middle WRITE cycle has sram_we_n=1; done timing unchanged (10 cycles).
- dst=(638,479), w=4, h=2 -> only (638,479) and (639,479) are written; addresses 307198 and 307199; 8 fetches still occur.
- sprite_w=0, h=5 -> done one cycle after start; sram_we_n never asserted.
- Second start pulse during a 4x4 blit -> ignored; exactly 16 fetches; exactly one done pulse.
- reset_n low during a WRITE cycle -> sram_we_n=1, sram_dq_oe=0 and busy=0 in the same cycle. A subsequent start runs a full blit correctly.
